cam_box_detect: RTL and testbench
=================================

// Module: cam_box_detect
// PURPOSE
//  Consumes the 1-bit thresholded pixel stream (thr_data/de/hs/vs) from the RGB
//  threshold stage. Tracks per-frame min/max X/Y and the hit count of set pixels.
//  At each frame boundary it publishes a bounding box for the overlay/LCD stage.
// PARAMETERS
//  H_ACTIVE  480  active pixels per line; pixels with x >= H_ACTIVE are ignored
//  V_ACTIVE  272  active lines per frame; lines with y >= V_ACTIVE are ignored
//  XW        10   X coordinate width
//  YW        10   Y coordinate width
//  CW        18   hit-counter width (saturating)
//  MIN_HITS  64   minimum hits for box_found=1
//  VS_POL    1    active level of thr_vs (1 = high)
// PORTS
//  clk        in   1   pixel clock
//  rst_n      in   1   async active-low reset
//  thr_data   in   1   binary pixel (1 = target colour); sampled only when thr_de=1
//  thr_de     in   1   data enable
//  thr_hs     in   1   line sync (unused for counting, kept for alignment)
//  thr_vs     in   1   frame sync, polarity per VS_POL
//  box_x0     out  XW  left edge (min x) of last completed frame
//  box_x1     out  XW  right edge (max x)
//  box_y0     out  YW  top edge (min y)
//  box_y1     out  YW  bottom edge (max y)
//  box_cnt    out  CW  hit count of last frame, saturated at 2^CW-1
//  box_found  out  1   level: box_cnt >= MIN_HITS for last frame
//  box_valid  out  1   1-cycle pulse when box_* outputs update
// BEHAVIOUR
//  - Reset: all outputs 0; x=y=0; accumulators cleared; state S_WAIT.
//  - Inputs registered once (de_d, vs_d). vs_rise = vs active edge (per VS_POL);
//    de_fall = de_d & ~thr_de.
//  - x counter: +1 per cycle with thr_de=1, cleared on de_fall; saturates at all-ones.
//  - y counter: +1 on de_fall, cleared on vs_rise; saturates at all-ones.
//  - Hit = thr_de & thr_data & x<H_ACTIVE & y<V_ACTIVE.
//  - Per hit:
//    - min_x/max_x/min_y/max_y updated with current (x,y).
//    - cnt+1, saturating.
//    - Accumulators after clear: min=all-ones, max=0, cnt=0.
//  - FSM:
//    - S_WAIT: ignore data until first vs_rise -> clear accum, go S_ACCUM.
//      No box_valid is produced for the partial frame after reset.
//    - S_ACCUM: accumulate hits; on vs_rise -> S_LATCH.
//    - S_LATCH (1 cycle):
//      - copy accum to outputs, box_valid=1.
//      - box_found=(cnt>=MIN_HITS).
//      - clear accum, reset y; -> S_ACCUM.
//  - Latency: box_valid asserts exactly 2 clk after thr_vs active edge at the input.
//  - cnt==0: box_x0=box_x1=box_y0=box_y1=0, box_found=0. Outputs never show the
//    all-ones sentinel.
//  - Hit in the same cycle as vs_rise: belongs to the old frame (counted before latch).
//  - vs_rise while in S_LATCH cannot occur (vs must toggle); not handled specially.
//  - Outputs hold between box_valid pulses.
//  - rst_n low mid-frame: immediate clear. The next frame boundary is treated as
//    the first (S_WAIT).
// TESTING
//  - T1 reset:
//    - rst_n=0 mid-frame -> all outputs 0.
//    - After release, first vs_rise gives no box_valid; second gives one pulse.
//  - T2 single block:
//    - 480x272 frame, hits only at x=100..149, y=50..89 (2000 px).
//    - Expect box_valid 2 clk after vs edge; x0=100 x1=149 y0=50 y1=89;
//      cnt=2000, found=1.
//  - T3 empty frame: no hits -> valid pulse, all coords 0, cnt=0, found=0.
//  - T4 sparse:
//    - 63 hits -> found=0, cnt=63.
//    - Next frame 64 hits -> found=1.
//  - T5 edges:
//    - Hits at (0,0) and (479,271) -> box 0,479,0,271.
//    - Hit at x=480 (de held 481 cycles) ignored.
//  - T6 saturation/polarity:
//    - CW=4 with 20 hits -> cnt=15.
//    - VS_POL=0 with inverted vs -> same results as T2.

Source files
------------

// File: rtl/cam_box_if.sv
// Thresholded pixel stream in, bounding-box result out.
interface cam_box_if #(
    parameter int XW = 10,
    parameter int YW = 10,
    parameter int CW = 18
);
    logic          thr_data;
    logic          thr_de;
    logic          thr_hs;
    logic          thr_vs;
    logic [XW-1:0] box_x0;
    logic [XW-1:0] box_x1;
    logic [YW-1:0] box_y0;
    logic [YW-1:0] box_y1;
    logic [CW-1:0] box_cnt;
    logic          box_found;
    logic          box_valid;

    modport master (
        output thr_data, thr_de, thr_hs, thr_vs,
        input  box_x0, box_x1, box_y0, box_y1,
        input  box_cnt, box_found, box_valid
    );

    modport slave (
        input  thr_data, thr_de, thr_hs, thr_vs,
        output box_x0, box_x1, box_y0, box_y1,
        output box_cnt, box_found, box_valid
    );
endinterface

// File: rtl/cam_box_detect.sv
// Per-frame bounding box and hit count of set pixels in a binary video stream.
module cam_box_detect #(
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int CW       = 18,
    parameter int MIN_HITS = 64,
    parameter bit VS_POL   = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    cam_box_if.slave  bus
);
    typedef enum logic [1:0] {S_WAIT, S_ACCUM, S_LATCH} state_t;

    state_t        state, nxt;
    logic          de_d, vs_d;
    logic [XW-1:0] x, min_x, max_x;
    logic [YW-1:0] y, min_y, max_y;
    logic [CW-1:0] cnt;
    logic          vs_rise, de_fall, hit, clr, latch;
    logic          unused;

    assign unused  = bus.thr_hs;
    assign vs_rise = (bus.thr_vs == VS_POL) & (vs_d != VS_POL);
    assign de_fall = de_d & ~bus.thr_de;
    assign hit     = bus.thr_de & bus.thr_data
                   & (32'(x) < H_ACTIVE) & (32'(y) < V_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_WAIT;
        else        state <= nxt;
    end

    always_comb begin
        nxt   = state;
        clr   = 1'b0;
        latch = 1'b0;
        unique case (state)
            S_WAIT: if (vs_rise) begin
                clr = 1'b1;
                nxt = S_ACCUM;
            end
            S_ACCUM: if (vs_rise) nxt = S_LATCH;
            S_LATCH: begin
                latch = 1'b1;
                clr   = 1'b1;
                nxt   = S_ACCUM;
            end
            default: nxt = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d <= 1'b0;
            vs_d <= ~VS_POL;
            x    <= '0;
            y    <= '0;
        end else begin
            de_d <= bus.thr_de;
            vs_d <= bus.thr_vs;
            if (de_fall)
                x <= '0;
            else if (bus.thr_de && x != '1)
                x <= x + XW'(1);
            if (vs_rise || latch)
                y <= '0;
            else if (de_fall && y != '1)
                y <= y + YW'(1);
        end
    end

    // Hits in S_WAIT belong to a partial frame and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_x <= '1;
            max_x <= '0;
            min_y <= '1;
            max_y <= '0;
            cnt   <= '0;
        end else if (clr) begin
            min_x <= '1;
            max_x <= '0;
            min_y <= '1;
            max_y <= '0;
            cnt   <= '0;
        end else if (hit && state != S_WAIT) begin
            if (x < min_x) min_x <= x;
            if (x > max_x) max_x <= x;
            if (y < min_y) min_y <= y;
            if (y > max_y) max_y <= y;
            if (cnt != '1) cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.box_x0    <= '0;
            bus.box_x1    <= '0;
            bus.box_y0    <= '0;
            bus.box_y1    <= '0;
            bus.box_cnt   <= '0;
            bus.box_found <= 1'b0;
            bus.box_valid <= 1'b0;
        end else begin
            bus.box_valid <= latch;
            if (latch) begin
                bus.box_cnt   <= cnt;
                bus.box_found <= 32'(cnt) >= MIN_HITS;
                if (cnt == '0) begin
                    bus.box_x0 <= '0;
                    bus.box_x1 <= '0;
                    bus.box_y0 <= '0;
                    bus.box_y1 <= '0;
                end else begin
                    bus.box_x0 <= min_x;
                    bus.box_x1 <= max_x;
                    bus.box_y0 <= min_y;
                    bus.box_y1 <= max_y;
                end
            end
        end
    end
endmodule

// File: tb/tb_cam_box_detect.sv
// Directed bench: default DUT plus CW=4 and VS_POL=0 variants on one stream.
module tb_cam_box_detect;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic data = 1'b0;
    logic de = 1'b0;
    logic hs = 1'b0;
    logic vs = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cam_box_if                b0 ();
    cam_box_if #(.CW(4))      b4 ();
    cam_box_if                bn ();

    assign b0.thr_data = data;
    assign b0.thr_de   = de;
    assign b0.thr_hs   = hs;
    assign b0.thr_vs   = vs;
    assign b4.thr_data = data;
    assign b4.thr_de   = de;
    assign b4.thr_hs   = hs;
    assign b4.thr_vs   = vs;
    assign bn.thr_data = data;
    assign bn.thr_de   = de;
    assign bn.thr_hs   = hs;
    assign bn.thr_vs   = ~vs;

    cam_box_detect dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    cam_box_detect #(.CW(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    cam_box_detect #(.VS_POL(1'b0)) dutn (.clk(clk), .rst_n(rst_n), .bus(bn.slave));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One line: de for len cycles, data set for x in [lo,hi] or x==pt.
    task automatic line(input int len, input int lo, input int hi, input int pt);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            de   = 1'b1;
            data = (i >= lo && i <= hi) || (i == pt);
        end
        @(negedge clk);
        de   = 1'b0;
        data = 1'b0;
        hs   = 1'b1;
        @(negedge clk);
        hs = 1'b0;
    endtask

    task automatic vs_edge(input bit pulse, input int x0, input int x1,
                           input int y0, input int y1, input int cnt,
                           input bit found);
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        check("valid_early", b0.box_valid, 0);
        @(negedge clk);
        check("valid", b0.box_valid, pulse);
        check("valid_neg", bn.box_valid, pulse);
        if (pulse) begin
            check("x0", b0.box_x0, x0);
            check("x1", b0.box_x1, x1);
            check("y0", b0.box_y0, y0);
            check("y1", b0.box_y1, y1);
            check("cnt", b0.box_cnt, cnt);
            check("found", b0.box_found, found);
        end
        @(negedge clk);
        check("valid_end", b0.box_valid, 0);
        vs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", b0.box_valid, 0);
        check("rst_cnt", b0.box_cnt, 0);
        check("rst_found", b0.box_found, 0);
        check("rst_x1", b0.box_x1, 0);
        rst_n = 1'b1;

        line(10, 0, 9, -1);
        vs_edge(0, 0, 0, 0, 0, 0, 0);

        for (int l = 0; l < 90; l++)
            line(150, l >= 50 ? 100 : 1, l >= 50 ? 149 : 0, -1);
        vs_edge(1, 100, 149, 50, 89, 2000, 1);
        check("neg_x0", bn.box_x0, 100);
        check("neg_x1", bn.box_x1, 149);
        check("neg_y0", bn.box_y0, 50);
        check("neg_y1", bn.box_y1, 89);
        check("neg_cnt", bn.box_cnt, 2000);
        check("neg_found", bn.box_found, 1);
        check("c4_sat", b4.box_cnt, 15);
        check("c4_found", b4.box_found, 0);

        line(20, 1, 0, -1);
        check("hold_cnt", b0.box_cnt, 2000);
        check("hold_x0", b0.box_x0, 100);
        vs_edge(1, 0, 0, 0, 0, 0, 0);

        line(100, 0, 62, -1);
        vs_edge(1, 0, 62, 0, 0, 63, 0);
        line(100, 0, 63, -1);
        vs_edge(1, 0, 63, 0, 0, 64, 1);

        line(30, 0, 19, -1);
        vs_edge(1, 0, 19, 0, 0, 20, 0);
        check("c4_cnt20", b4.box_cnt, 15);
        check("c4_x1", b4.box_x1, 19);

        line(481, 0, 0, 480);
        for (int l = 1; l < 271; l++)
            line(1, 1, 0, -1);
        line(481, 479, 480, -1);
        line(10, 5, 5, -1);
        vs_edge(1, 0, 479, 0, 271, 2, 0);

        line(50, 0, 49, -1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_x1", b0.box_x1, 0);
        check("mid_rst_y1", b0.box_y1, 0);
        check("mid_rst_cnt", b0.box_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        line(40, 0, 39, -1);
        vs_edge(0, 0, 0, 0, 0, 0, 0);
        line(40, 10, 39, -1);
        vs_edge(1, 10, 39, 0, 0, 30, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
